muldiv_sequencer: RTL and testbench

Sequences the multicycle multiply and divide units for the MULT/DIV/MULTU/DIVU instructions of the multicycle CPU. It accepts a one-operation request from `control_unit` and issues a one-cycle start pulse to `mult` or `div`. It waits a fixed, parameterised number of cycles, then commits the result by pulsing `HI_write`/`LO_write` with `HiLoSrc` steering the HI/LO muxes. It also reports divide-by-zero as a one-cycle exception pulse and supports cancellation by the control unit.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_cnt.sv | 27 ++
 rtl/muldiv_sequencer.sv | 114 +++++++++++
 tb/tb_muldiv_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer and the HI/LO mux select.
package muldiv_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_EXC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_START = S_START,
        ST_RUN   = S_RUN,
        ST_WRITE = S_WRITE,
        ST_EXC   = S_EXC
    } state_t;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_MULT = 1'b1;

endpackage

// File: rtl/muldiv_cnt.sv
// Loadable down-counter timing the multicycle mult/div latency.
module muldiv_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             en,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (en && !zero) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Issues start pulses to mult/div, waits a fixed latency, then commits HI/LO or raises div_exc.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 33,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic op_valid,
    input  logic op_sel,
    input  logic cancel,
    input  logic divzero,
    output logic op_ready,
    output logic mult_start,
    output logic div_start,
    output logic HI_write,
    output logic LO_write,
    output logic HiLoSrc,
    output logic busy,
    output logic done,
    output logic div_exc
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic             sel_q;
    logic             accept;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;

    // A cancel in IDLE blocks acceptance for that cycle.
    assign accept = (state == ST_IDLE) && op_valid && !cancel;

    muldiv_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (op_sel ? MULT_LOAD : DIV_LOAD),
        .en         (state == ST_RUN),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            sel_q <= OP_DIV;
        end else begin
            state <= state_next;
            if (accept) begin
                sel_q <= op_sel;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        HI_write   = 1'b0;
        LO_write   = 1'b0;
        done       = 1'b0;
        div_exc    = 1'b0;

        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (accept) state_next = ST_START;
            end
            ST_START: begin
                mult_start = (sel_q == OP_MULT);
                div_start  = (sel_q == OP_DIV);
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (sel_q == OP_DIV && divzero) state_next = ST_EXC;
                else if (cnt_zero)             state_next = ST_WRITE;
            end
            ST_WRITE: begin
                HI_write   = 1'b1;
                LO_write   = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_EXC: begin
                div_exc    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Cancel outranks everything and masks the pulses of the cycle it arrives in.
        if (cancel && state != ST_IDLE) begin
            state_next = ST_IDLE;
            mult_start = 1'b0;
            div_start  = 1'b0;
            HI_write   = 1'b0;
            LO_write   = 1'b0;
            done       = 1'b0;
            div_exc    = 1'b0;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign HiLoSrc = sel_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with MULT_CYCLES=33, DIV_CYCLES=4.
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic op_valid, op_sel, cancel, divzero;
    logic op_ready, mult_start, div_start, HI_write, LO_write, HiLoSrc, busy, done, div_exc;

    int checks = 0;
    int errors = 0;

    int cyc;
    int n_mstart, first_mstart, n_dstart, first_dstart, last_dstart;
    int n_hi, n_lo, first_hi, n_done, n_exc, first_exc, first_ready, hilo_at_write;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .MULT_CYCLES (33),
        .DIV_CYCLES  (4),
        .CNT_W       (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_sel     (op_sel),
        .cancel     (cancel),
        .divzero    (divzero),
        .op_ready   (op_ready),
        .mult_start (mult_start),
        .div_start  (div_start),
        .HI_write   (HI_write),
        .LO_write   (LO_write),
        .HiLoSrc    (HiLoSrc),
        .busy       (busy),
        .done       (done),
        .div_exc    (div_exc)
    );

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clear_rec();
        cyc = 0;
        n_mstart = 0; first_mstart = -1;
        n_dstart = 0; first_dstart = -1; last_dstart = -1;
        n_hi = 0; n_lo = 0; first_hi = -1; n_done = 0;
        n_exc = 0; first_exc = -1; first_ready = -1; hilo_at_write = -1;
    endtask

    // One clock; optionally raise cancel mid-cycle, then record the cycle's outputs.
    task automatic step(input bit cancel_mid);
        @(posedge clk);
        #1;
        if (cancel_mid) cancel = 1'b1;
        #1;
        cyc++;
        if (mult_start) begin n_mstart++; if (first_mstart < 0) first_mstart = cyc; end
        if (div_start) begin
            n_dstart++; last_dstart = cyc;
            if (first_dstart < 0) first_dstart = cyc;
        end
        if (HI_write) begin
            n_hi++; hilo_at_write = int'(HiLoSrc);
            if (first_hi < 0) first_hi = cyc;
        end
        if (LO_write) n_lo++;
        if (done) n_done++;
        if (div_exc) begin n_exc++; if (first_exc < 0) first_exc = cyc; end
        if (op_ready && first_ready < 0) first_ready = cyc;
    endtask

    task automatic steps_to(input int last);
        while (cyc < last) step(1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_op_ready"}, int'(op_ready), 1);
        check({tag, "_pulses"}, int'({mult_start, div_start, HI_write, LO_write, done, div_exc}), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_hilosrc"}, int'(HiLoSrc), 0);
    endtask

    initial begin
        reset = 1'b0; op_valid = 1'b0; op_sel = 1'b0; cancel = 1'b0; divzero = 1'b0;
        #12;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #2;

        // Multiply, N=33: start at 1, write at 35, ready at 36.
        clear_rec();
        op_valid = 1'b1; op_sel = 1'b1;
        step(1'b0);
        op_valid = 1'b0;
        check("mul_busy_start", int'(busy), 1);
        steps_to(36);
        check("mul_mstart_n", n_mstart, 1);
        check("mul_mstart_cyc", first_mstart, 1);
        check("mul_dstart_n", n_dstart, 0);
        check("mul_write_cyc", first_hi, 35);
        check("mul_hi_n", n_hi, 1);
        check("mul_lo_n", n_lo, 1);
        check("mul_done_n", n_done, 1);
        check("mul_hilosrc", hilo_at_write, 1);
        check("mul_ready_cyc", first_ready, 36);

        // Divide, N=4: start at 1, write at 6, ready at 7.
        clear_rec();
        op_valid = 1'b1; op_sel = 1'b0;
        step(1'b0);
        op_valid = 1'b0;
        steps_to(7);
        check("div_dstart_cyc", first_dstart, 1);
        check("div_mstart_n", n_mstart, 0);
        check("div_write_cyc", first_hi, 6);
        check("div_hilosrc", hilo_at_write, 0);
        check("div_ready_cyc", first_ready, 7);
        check("div_exc_n", n_exc, 0);

        // Divide by zero from the first RUN cycle: EXC at 3, IDLE at 4.
        clear_rec();
        op_valid = 1'b1; op_sel = 1'b0;
        step(1'b0);
        op_valid = 1'b0;
        divzero = 1'b1;
        steps_to(5);
        check("dz_exc_cyc", first_exc, 3);
        check("dz_exc_n", n_exc, 1);
        check("dz_hi_n", n_hi, 0);
        check("dz_done_n", n_done, 0);
        check("dz_ready_cyc", first_ready, 4);

        // Same divzero during a multiply has no effect.
        clear_rec();
        op_valid = 1'b1; op_sel = 1'b1;
        step(1'b0);
        op_valid = 1'b0;
        steps_to(36);
        divzero = 1'b0;
        check("mdz_exc_n", n_exc, 0);
        check("mdz_write_cyc", first_hi, 35);
        check("mdz_ready_cyc", first_ready, 36);

        // Cancel at T+10 of a multiply: IDLE at 11, never writes.
        clear_rec();
        op_valid = 1'b1; op_sel = 1'b1;
        step(1'b0);
        op_valid = 1'b0;
        steps_to(9);
        step(1'b1);
        step(1'b0);
        cancel = 1'b0;
        steps_to(40);
        check("can_ready_cyc", first_ready, 11);
        check("can_hi_n", n_hi, 0);
        check("can_lo_n", n_lo, 0);
        check("can_done_n", n_done, 0);

        // Cancel coincident with WRITE of a divide suppresses the write.
        clear_rec();
        op_valid = 1'b1; op_sel = 1'b0;
        step(1'b0);
        op_valid = 1'b0;
        steps_to(5);
        step(1'b1);
        check("cw_hi_now", int'(HI_write), 0);
        check("cw_done_now", int'(done), 0);
        step(1'b0);
        cancel = 1'b0;
        steps_to(8);
        check("cw_hi_n", n_hi, 0);
        check("cw_done_n", n_done, 0);
        check("cw_ready_cyc", first_ready, 7);

        // Cancel in IDLE blocks acceptance for that cycle only.
        clear_rec();
        op_valid = 1'b1; op_sel = 1'b0; cancel = 1'b1;
        step(1'b0);
        check("ci_blocked", int'(busy), 0);
        cancel = 1'b0;
        step(1'b0);
        op_valid = 1'b0;
        check("ci_accepted", int'(busy), 1);
        steps_to(10);
        check("ci_dstart_cyc", first_dstart, 2);

        // Asynchronous reset mid-RUN.
        clear_rec();
        op_valid = 1'b1; op_sel = 1'b1;
        step(1'b0);
        op_valid = 1'b0;
        steps_to(5);
        reset = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        #1;
        reset = 1'b1;
        clear_rec();
        steps_to(40);
        check("rst_no_write", n_hi, 0);

        // op_valid held through a divide is accepted exactly once more, at the first IDLE.
        clear_rec();
        op_valid = 1'b1; op_sel = 1'b0;
        steps_to(8);
        op_valid = 1'b0;
        steps_to(16);
        check("hold_dstart_n", n_dstart, 2);
        check("hold_dstart_last", last_dstart, 8);
        check("hold_hi_n", n_hi, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
